multiply: RTL and testbench

MULTIPLY -- requirements
Module: multiply

---
 rtl/multiply.sv | 53 +++++
 tb/tb_multiply.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/multiply.sv
// Lane-parallel multiplier: Ndata independent Nbits x Nbits products, registered, 1-cycle latency.
// Define MULTIPLY_SIGNED_EN for two's-complement lanes; default build is unsigned.
module multiply #(
   parameter int unsigned Nbits = 4,
   parameter int unsigned Ndata = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [Ndata*Nbits-1:0]     multiplier,
   input  logic [Ndata*Nbits-1:0]     multiplicand,
   output logic                       out_valid,
   output logic [Ndata*2*Nbits-1:0]   mult_out
);

   logic [Ndata*2*Nbits-1:0] prod_d, prod_q;
   logic                     valid_q;
   logic [2*Nbits-1:0]       a_ext, b_ext;

   // Operands are extended to the full product width so the truncated
   // 2*Nbits product is exact for both unsigned and two's-complement lanes.
   always_comb begin
      prod_d = '0;
      a_ext  = '0;
      b_ext  = '0;
      for (int i = 0; i < int'(Ndata); i++) begin
`ifdef MULTIPLY_SIGNED_EN
         a_ext = {{Nbits{multiplier[i*Nbits+Nbits-1]}}, multiplier[i*Nbits +: Nbits]};
         b_ext = {{Nbits{multiplicand[i*Nbits+Nbits-1]}}, multiplicand[i*Nbits +: Nbits]};
`else
         a_ext = {{Nbits{1'b0}}, multiplier[i*Nbits +: Nbits]};
         b_ext = {{Nbits{1'b0}}, multiplicand[i*Nbits +: Nbits]};
`endif
         prod_d[i*2*Nbits +: 2*Nbits] = a_ext * b_ext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         prod_q  <= '0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            prod_q <= prod_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign mult_out  = prod_q;

endmodule

// File: tb/tb_multiply.sv
// Self-checking bench for multiply (Nbits=4, Ndata=8): directed table, hold, reset and random streams.
module tb_multiply;

   localparam int unsigned Nbits = 4;
   localparam int unsigned Ndata = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] multiplier, multiplicand;
   logic        out_valid;
   logic [63:0] mult_out;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       name;
      logic [31:0] m;
      logic [31:0] c;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[$];

   multiply #(.Nbits(Nbits), .Ndata(Ndata)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .out_valid    (out_valid),
      .mult_out     (mult_out)
   );

   always #5 clk = ~clk;

   // Reference: each lane as an integer, multiplied with plain arithmetic.
   function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] c);
      logic [63:0] r;
      int a, b, p;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         a = int'((m >> (4*i)) & 32'hF);
         b = int'((c >> (4*i)) & 32'hF);
`ifdef MULTIPLY_SIGNED_EN
         if (a >= 8) a = a - 16;
         if (b >= 8) b = b - 16;
`endif
         p = (a * b) & 255;
         r = r | (64'(p) << (8*i));
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic step(input logic v, input logic [31:0] m, input logic [31:0] c);
      @(negedge clk);
      in_valid     = v;
      multiplier   = m;
      multiplicand = c;
      @(posedge clk);
      #1;
   endtask

   logic [63:0] exp_out;
   logic [31:0] rm, rc;
   logic        rv;

   initial begin
      // Directed vectors; expected values written from the lane rules by hand.
      vecs.push_back('{"ramp", 32'h7654_3210, 32'h0123_4567, 64'h00_06_0A_0C_0C_0A_06_00});
`ifdef MULTIPLY_SIGNED_EN
      vecs.push_back('{"max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0101_0101_0101_0101});
      vecs.push_back('{"f_x_2", 32'hFFFF_FFFF, 32'h2222_2222, 64'hFEFE_FEFE_FEFE_FEFE});
`else
      vecs.push_back('{"max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hE1E1_E1E1_E1E1_E1E1});
      vecs.push_back('{"f_x_2", 32'hFFFF_FFFF, 32'h2222_2222, 64'h1E1E_1E1E_1E1E_1E1E});
`endif
      vecs.push_back('{"zero_x_n", 32'h0000_0000, 32'h9A5F_3C71, 64'h0});
      vecs.push_back('{"n_x_zero", 32'hFEDC_BA98, 32'h0000_0000, 64'h0});
      vecs.push_back('{"8_x_8", 32'h8888_8888, 32'h8888_8888, 64'h4040_4040_4040_4040});

      // Reset with live inputs
      rst = 1'b1; in_valid = 1'b1; multiplier = 32'hFFFF_FFFF; multiplicand = 32'h1234_5678;
      #1;
      check("reset_out_async", mult_out, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", mult_out, 64'h0);
      check("reset_valid", {63'h0, out_valid}, 64'h0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      check("post_reset_out", mult_out, 64'h0);
      check("post_reset_valid", {63'h0, out_valid}, 64'h0);

      // Table, back to back
      foreach (vecs[k]) begin
         step(1'b1, vecs[k].m, vecs[k].c);
         check({vecs[k].name, "_valid"}, {63'h0, out_valid}, 64'h1);
         check(vecs[k].name, mult_out, vecs[k].exp);
         check({vecs[k].name, "_model"}, mult_out, model(vecs[k].m, vecs[k].c));
      end

      // Hold
      step(1'b1, 32'h1357_9BDF, 32'h2468_ACE1);
      exp_out = model(32'h1357_9BDF, 32'h2468_ACE1);
      check("hold_load", mult_out, exp_out);
      step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("hold_valid", {63'h0, out_valid}, 64'h0);
      check("hold_out", mult_out, exp_out);
      step(1'b0, 32'h0, 32'h7777_7777);
      check("hold_out2", mult_out, exp_out);

      // Streaming with mid-stream reset after vector 3
      for (int i = 1; i <= 3; i++) begin
         rm = $urandom; rc = $urandom;
         step(1'b1, rm, rc);
         exp_out = model(rm, rc);
         check($sformatf("stream%0d_valid", i), {63'h0, out_valid}, 64'h1);
         check($sformatf("stream%0d", i), mult_out, exp_out);
      end
      rst = 1'b1;
      #1;
      check("midrst_out", mult_out, 64'h0);
      check("midrst_valid", {63'h0, out_valid}, 64'h0);
      step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("midrst_ignored", mult_out, 64'h0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      check("midrst_stale_valid", {63'h0, out_valid}, 64'h0);
      check("midrst_stale_out", mult_out, 64'h0);
      for (int i = 4; i <= 5; i++) begin
         rm = $urandom; rc = $urandom;
         step(1'b1, rm, rc);
         exp_out = model(rm, rc);
         check($sformatf("stream%0d_valid", i), {63'h0, out_valid}, 64'h1);
         check($sformatf("stream%0d", i), mult_out, exp_out);
      end

      // Random traffic with random valid gaps
      for (int i = 0; i < 60; i++) begin
         rv = 1'($urandom_range(0, 3) != 0);
         rm = $urandom; rc = $urandom;
         step(rv, rm, rc);
         if (rv) exp_out = model(rm, rc);
         check($sformatf("rand%0d_valid", i), {63'h0, out_valid}, {63'h0, rv});
         check($sformatf("rand%0d", i), mult_out, exp_out);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
